// File: rtl/sys_reset_pkg.sv
// Shared types and widths for the system reset sequencer.
package sys_reset_pkg;

  typedef enum logic [1:0] {
    HOLD      = 2'd0,
    WAIT_LOCK = 2'd1,
    SETTLE    = 2'd2,
    RUN       = 2'd3
  } rst_state_t;

  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned LOSS_CNT_W  = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous level, with a selectable reset value.
module sync_2ff
  import sys_reset_pkg::*;
#(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sr;

  always_ff @(posedge clock) begin
    if (reset) begin
      sr <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      sr <= {sr[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sr[SYNC_STAGES-1];

endmodule

// File: rtl/sys_reset_seq.sv
// Reset sequencer: qualifies PLL lock and the board button, drives a glitch-free sys_reset.
// Optional button debounce is enabled by defining SYS_RESET_DEBOUNCE_EN.
module sys_reset_seq
  import sys_reset_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES     = 16,
  parameter int unsigned LOCK_CYCLES     = 1024,
  parameter int unsigned DEBOUNCE_CYCLES = 16000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  pll_locked,
  input  logic                  ext_reset_n,
  output logic                  sys_reset,
  output logic                  ready,
  output logic [1:0]            state,
  output logic [LOSS_CNT_W-1:0] lock_loss_count
);

  localparam int unsigned CNT_MAX = (HOLD_CYCLES > LOCK_CYCLES) ? HOLD_CYCLES : LOCK_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;

  if (HOLD_CYCLES < 1 || LOCK_CYCLES < 1 || DEBOUNCE_CYCLES < 1) begin : g_param_err
    $error("sys_reset_seq: cycle parameters must be at least 1");
  end

  logic locked_s;
  logic btn_n_s;
  logic btn_press;

  rst_state_t            state_q, state_next;
  logic [CNT_W-1:0]      cnt_q, cnt_next;
  logic [LOSS_CNT_W-1:0] loss_q, loss_next;

  sync_2ff #(.RESET_VAL(1'b0)) u_sync_lock (
    .clock (clock),
    .reset (reset),
    .d     (pll_locked),
    .q     (locked_s)
  );

  sync_2ff #(.RESET_VAL(1'b1)) u_sync_btn (
    .clock (clock),
    .reset (reset),
    .d     (ext_reset_n),
    .q     (btn_n_s)
  );

`ifdef SYS_RESET_DEBOUNCE_EN
  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES) + 1;

  logic [DB_W-1:0] db_cnt_q, db_cnt_next;

  // Counts consecutive low cycles of the synchronised button, saturating at the window.
  always_comb begin
    db_cnt_next = db_cnt_q;
    if (btn_n_s) begin
      db_cnt_next = '0;
    end else if (db_cnt_q != DB_W'(DEBOUNCE_CYCLES)) begin
      db_cnt_next = db_cnt_q + DB_W'(1);
    end
  end

  assign btn_press = (db_cnt_q == DB_W'(DEBOUNCE_CYCLES));
`else
  assign btn_press = ~btn_n_s;
`endif

  // Next state and counters; a button press overrides every other transition.
  always_comb begin
    state_next = state_q;
    cnt_next   = cnt_q;
    loss_next  = loss_q;

    if (state_q == RUN && !locked_s && loss_q != '1) begin
      loss_next = loss_q + LOSS_CNT_W'(1);
    end

    if (btn_press) begin
      state_next = HOLD;
      cnt_next   = '0;
    end else begin
      unique case (state_q)
        HOLD: begin
          if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
            state_next = WAIT_LOCK;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_q + CNT_W'(1);
          end
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            state_next = SETTLE;
            cnt_next   = '0;
          end
        end
        SETTLE: begin
          if (!locked_s) begin
            state_next = WAIT_LOCK;
            cnt_next   = '0;
          end else if (cnt_q == CNT_W'(LOCK_CYCLES - 1)) begin
            state_next = RUN;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_q + CNT_W'(1);
          end
        end
        RUN: begin
          if (!locked_s) begin
            state_next = WAIT_LOCK;
          end
        end
        default: begin
          state_next = HOLD;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // sys_reset follows the next state so it only moves on transitions into or out of RUN.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= HOLD;
      cnt_q     <= '0;
      loss_q    <= '0;
      sys_reset <= 1'b1;
      ready     <= 1'b0;
`ifdef SYS_RESET_DEBOUNCE_EN
      db_cnt_q  <= '0;
`endif
    end else begin
      state_q   <= state_next;
      cnt_q     <= cnt_next;
      loss_q    <= loss_next;
      sys_reset <= (state_next != RUN);
      ready     <= (state_next == RUN);
`ifdef SYS_RESET_DEBOUNCE_EN
      db_cnt_q  <= db_cnt_next;
`endif
    end
  end

  assign state           = state_q;
  assign lock_loss_count = loss_q;

endmodule

// File: tb/tb_sys_reset_seq.sv
// Bench for sys_reset_seq: directed timing scenarios plus random stimulus against a behavioural model.
module tb_sys_reset_seq;

  localparam int unsigned H = 4;
  localparam int unsigned L = 8;
  localparam int unsigned D = 10;

  logic       clock = 1'b0;
  logic       reset;
  logic       pll_locked;
  logic       ext_reset_n;
  logic       sys_reset;
  logic       ready;
  logic [1:0] state;
  logic [7:0] lock_loss_count;

  int tests = 0;
  int fails = 0;

  // Behavioural model: phase 0..3, countdowns instead of up-counters
  int m_phase, m_hold_left, m_need, m_loss;
  bit m_sr;
  bit lk1, lk2, bt1, bt2;
`ifdef SYS_RESET_DEBOUNCE_EN
  int m_db_low;
`endif

  sys_reset_seq #(
    .HOLD_CYCLES     (H),
    .LOCK_CYCLES     (L),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .pll_locked      (pll_locked),
    .ext_reset_n     (ext_reset_n),
    .sys_reset       (sys_reset),
    .ready           (ready),
    .state           (state),
    .lock_loss_count (lock_loss_count)
  );

  always #5 clock = ~clock;

  task automatic model_step(input bit r, input bit p, input bit b);
    bit ls, bs, press;
    if (r) begin
      m_phase = 0; m_hold_left = H; m_need = L; m_loss = 0; m_sr = 1'b1;
      lk1 = 1'b0; lk2 = 1'b0; bt1 = 1'b1; bt2 = 1'b1;
`ifdef SYS_RESET_DEBOUNCE_EN
      m_db_low = 0;
`endif
      return;
    end
    ls = lk2;
    bs = bt2;
`ifdef SYS_RESET_DEBOUNCE_EN
    press = (m_db_low >= D);
    if (bs) m_db_low = 0;
    else if (m_db_low < D) m_db_low++;
`else
    press = !bs;
`endif
    if (m_phase == 3 && !ls && m_loss < 255) m_loss++;
    if (press) begin
      m_phase = 0;
      m_hold_left = H;
    end else begin
      case (m_phase)
        0: begin
          m_hold_left--;
          if (m_hold_left == 0) m_phase = 1;
        end
        1: if (ls) begin m_phase = 2; m_need = L; end
        2: begin
          if (!ls) m_phase = 1;
          else begin
            m_need--;
            if (m_need == 0) m_phase = 3;
          end
        end
        3: if (!ls) m_phase = 1;
        default: m_phase = 0;
      endcase
    end
    lk2 = lk1; lk1 = p;
    bt2 = bt1; bt1 = b;
    m_sr = (m_phase != 3);
  endtask

  // One clock edge, then compare every output with the model.
  task automatic tick();
    bit r, p, b;
    r = reset; p = pll_locked; b = ext_reset_n;
    @(posedge clock);
    #1;
    model_step(r, p, b);
    tests++;
    if (state !== 2'(m_phase) || sys_reset !== m_sr || ready !== !m_sr ||
        lock_loss_count !== 8'(m_loss)) begin
      fails++;
      $display("FAIL model t=%0t state=%0d want %0d sys_reset=%b want %b ready=%b loss=%0d want %0d",
               $time, state, m_phase, sys_reset, m_sr, ready, lock_loss_count, m_loss);
    end
  endtask

  task automatic wait_release(output int n);
    n = 0;
    while (sys_reset !== 1'b0 && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; pll_locked = 1'b1; ext_reset_n = 1'b1;
    repeat (3) tick();
    tests++; if (sys_reset !== 1'b1) begin fails++; $display("FAIL reset_sys_reset got %b want 1", sys_reset); end
    tests++; if (ready !== 1'b0) begin fails++; $display("FAIL reset_ready got %b want 0", ready); end
    tests++; if (state !== 2'd0) begin fails++; $display("FAIL reset_state got %0d want 0", state); end
    tests++; if (lock_loss_count !== 8'd0) begin fails++; $display("FAIL reset_loss got %0d want 0", lock_loss_count); end
  endtask

  task automatic test_powerup();
    int n;
    reset = 1'b1; pll_locked = 1'b1; ext_reset_n = 1'b1;
    tick();
    reset = 1'b0;
    wait_release(n);
    tests++; if (n != H + 1 + L) begin fails++; $display("FAIL powerup_edges got %0d want %0d", n, H + 1 + L); end
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL powerup_ready got %b want 1", ready); end
  endtask

  task automatic test_lock_acquire();
    int n;
    reset = 1'b1; pll_locked = 1'b0; ext_reset_n = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    repeat (50) tick();
    tests++; if (state !== 2'd1) begin fails++; $display("FAIL acq_wait_state got %0d want 1", state); end
    pll_locked = 1'b1;
    tick();
    tick();
    tests++; if (state !== 2'd1) begin fails++; $display("FAIL acq_e1_state got %0d want 1", state); end
    tick();
    tests++; if (state !== 2'd2) begin fails++; $display("FAIL acq_e2_state got %0d want 2", state); end
    wait_release(n);
    tests++; if (n != L) begin fails++; $display("FAIL acq_settle_edges got %0d want %0d", n, L); end
  endtask

  task automatic test_settle_dropout();
    int n;
    reset = 1'b1; pll_locked = 1'b0; ext_reset_n = 1'b1;
    tick();
    reset = 1'b0;
    repeat (10) tick();
    pll_locked = 1'b1;
    n = 0;
    while (state !== 2'd2 && n < 50) begin tick(); n++; end
    repeat (5) tick();
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    tick();
    tests++; if (state !== 2'd2) begin fails++; $display("FAIL drop_e1_state got %0d want 2", state); end
    tick();
    tests++; if (state !== 2'd1) begin fails++; $display("FAIL drop_e2_state got %0d want 1", state); end
    tick();
    tests++; if (state !== 2'd2) begin fails++; $display("FAIL drop_e3_state got %0d want 2", state); end
    wait_release(n);
    tests++; if (n != L) begin fails++; $display("FAIL drop_requal_edges got %0d want %0d", n, L); end
    tests++; if (lock_loss_count !== 8'd0) begin fails++; $display("FAIL drop_loss got %0d want 0", lock_loss_count); end
  endtask

  task automatic test_run_loss();
    int n;
    for (int i = 0; i < 300; i++) begin
      pll_locked = 1'b0;
      tick();
      pll_locked = 1'b1;
      tick();
      tests++; if (sys_reset !== 1'b0) begin fails++; $display("FAIL loss_e1_sys_reset pulse %0d got %b want 0", i, sys_reset); end
      tick();
      tests++; if (sys_reset !== 1'b1) begin fails++; $display("FAIL loss_e2_sys_reset pulse %0d got %b want 1", i, sys_reset); end
      wait_release(n);
    end
    tests++; if (lock_loss_count !== 8'd255) begin fails++; $display("FAIL loss_saturate got %0d want 255", lock_loss_count); end
  endtask

  task automatic test_reset_mid_run();
    int n;
    tests++; if (state !== 2'd3) begin fails++; $display("FAIL midrun_pre_state got %0d want 3", state); end
    reset = 1'b1;
    tick();
    tests++; if (sys_reset !== 1'b1) begin fails++; $display("FAIL midrun_sys_reset got %b want 1", sys_reset); end
    tests++; if (lock_loss_count !== 8'd0) begin fails++; $display("FAIL midrun_loss got %0d want 0", lock_loss_count); end
    reset = 1'b0;
    wait_release(n);
    tests++; if (n != H + 1 + L) begin fails++; $display("FAIL midrun_release got %0d want %0d", n, H + 1 + L); end
  endtask

`ifdef SYS_RESET_DEBOUNCE_EN
  task automatic test_button();
    int n;
    ext_reset_n = 1'b0;
    repeat (D - 1) tick();
    ext_reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      tests++; if (state !== 2'd3) begin fails++; $display("FAIL glitch_state cycle %0d got %0d want 3", i, state); end
    end
    ext_reset_n = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i == 11) begin
        tests++; if (sys_reset !== 1'b0) begin fails++; $display("FAIL press_e11 got %b want 0", sys_reset); end
      end
    end
    ext_reset_n = 1'b1;
    tick();
    tests++; if (sys_reset !== 1'b1) begin fails++; $display("FAIL press_e12 got %b want 1", sys_reset); end
    tests++; if (state !== 2'd0) begin fails++; $display("FAIL press_state got %0d want 0", state); end
    wait_release(n);
    tests++; if (state !== 2'd3) begin fails++; $display("FAIL press_rerun got %0d want 3", state); end
  endtask
`else
  task automatic test_button();
    int n;
    ext_reset_n = 1'b0;
    tick();
    ext_reset_n = 1'b1;
    tick();
    tests++; if (sys_reset !== 1'b0) begin fails++; $display("FAIL btn_e1 got %b want 0", sys_reset); end
    tick();
    tests++; if (sys_reset !== 1'b1) begin fails++; $display("FAIL btn_e2 got %b want 1", sys_reset); end
    tests++; if (state !== 2'd0) begin fails++; $display("FAIL btn_state got %0d want 0", state); end
    wait_release(n);
    tests++; if (n != H + 1 + L) begin fails++; $display("FAIL btn_release got %0d want %0d", n, H + 1 + L); end
  endtask
`endif

  task automatic test_random();
    int btn_left = 0;
    reset = 1'b1; pll_locked = 1'b1; ext_reset_n = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 39) == 0) pll_locked = ~pll_locked;
      if (btn_left > 0) begin
        ext_reset_n = 1'b0;
        btn_left--;
      end else begin
        ext_reset_n = 1'b1;
        if ($urandom_range(0, 49) == 0) btn_left = int'($urandom_range(1, 15));
      end
      reset = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; pll_locked = 1'b0; ext_reset_n = 1'b1;
    test_reset();
    test_powerup();
    test_lock_acquire();
    test_settle_dropout();
    test_run_loss();
    test_reset_mid_run();
    test_button();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sys_reset_seq.md
# sys_reset_seq

Reset sequencer sitting directly downstream of the iCE40 system PLL on the Alchitry Cu board. It runs on the PLL output clock, synchronises and qualifies the PLL lock indicator and the board reset button, and produces the single registered, active-high `sys_reset` that holds the rv32i core and its peripherals in reset until the clock is proven stable. It also counts lock-loss events for debug.

## Interface
- `HOLD_CYCLES`, 16: cycles spent in HOLD after `reset` deasserts or a button press; must be ≥ 1.
- `LOCK_CYCLES`, 1024: consecutive synchronised-lock cycles required before release; must be ≥ 1.
- `DEBOUNCE_CYCLES`, 16000: button stable-low cycles, about 1 ms at 16 MHz. Used only with `SYS_RESET_DEBOUNCE_EN`.
- `clock` in 1: PLL output clock; the only clock.
- `reset` in 1: synchronous, active-high reset.
- `pll_locked` in 1: PLL lock; asynchronous to `clock`.
- `ext_reset_n` in 1: raw board button, active-low; asynchronous.
- `sys_reset` out 1: registered, active-high system reset.
- `ready` out 1: registered, always equal to `~sys_reset`.
- `state` out 2: current state encoding, for debug.
- `lock_loss_count` out 8: saturating count of lock losses seen in RUN.

## Operation
- `pll_locked` and `ext_reset_n` each pass through a 2-flop synchronizer, giving `locked_s` and `btn_n_s`. Synchronizer flops reset to 0 and 1 respectively.
- `btn_press` depends on the build:
  - with debounce: asserts once `btn_n_s` has been low for `DEBOUNCE_CYCLES` consecutive cycles; stays high while `btn_n_s` remains low.
  - without debounce: `btn_press = ~btn_n_s`.
- States, encoded 0..3:
  - HOLD (0): counter increments each cycle. After `HOLD_CYCLES` cycles, go to WAIT_LOCK. While `btn_press` is high, the counter is held at 0.
  - WAIT_LOCK (1): when `locked_s` is high, go to SETTLE with counter = 0.
  - SETTLE (2): counter increments while `locked_s` is high. When counter = `LOCK_CYCLES`-1 and `locked_s` is high, go to RUN. If `locked_s` goes low, go to WAIT_LOCK.
  - RUN (3): if `locked_s` goes low, go to WAIT_LOCK.
- `btn_press` in any state forces HOLD. It has priority over every other transition.
- `lock_loss_count` increments, saturating at 255, on every cycle where the state is RUN and `locked_s` is low. This includes a cycle where `btn_press` is also high.
- `sys_reset` is loaded with `(state_next != RUN)`. It can only change on a state transition into or out of RUN, so it never glitches.
- Counter width is `$clog2(max(HOLD_CYCLES, LOCK_CYCLES))+1` bits. The debounce counter is sized separately and saturates at `DEBOUNCE_CYCLES`.

## Timing
- While `reset` is high: state = HOLD, all counters 0, `sys_reset` = 1, `ready` = 0, `state` = 0, `lock_loss_count` = 0.
- Asserting `reset` mid-RUN sets `sys_reset` = 1 at the next edge.
- From `reset` deasserting, with `pll_locked` already high and stable, `sys_reset` falls after exactly HOLD_CYCLES + 1 + LOCK_CYCLES edges. Synchronizer latency is hidden under HOLD when `HOLD_CYCLES` ≥ 2.
- Lock acquisition: if `pll_locked` rises before sampling edge e0 while in WAIT_LOCK, `locked_s` goes high after e1, the state enters SETTLE at e2, and `sys_reset` falls at e2 + LOCK_CYCLES.
- Lock loss in RUN: `pll_locked` low at e0 gives `sys_reset` = 1 at e2, and the count increments at that same edge.
- A one-cycle `locked_s` dropout in SETTLE restarts qualification from WAIT_LOCK.
- Button, with debounce: low at e0 and held gives `sys_reset` high at e0 + 2 + DEBOUNCE_CYCLES. Any bounce shorter than `DEBOUNCE_CYCLES` has no effect.

## Configuration
- `SYS_RESET_DEBOUNCE_EN` defined: debounce counter is present, and `DEBOUNCE_CYCLES` is honoured.
- Not defined: there is no debounce logic. A synchronised low on `ext_reset_n` forces HOLD after 2 cycles of synchronizer latency. `DEBOUNCE_CYCLES` is ignored.

## Structure
- Package `sys_reset_pkg` holds:
  - `typedef enum logic [1:0] {HOLD, WAIT_LOCK, SETTLE, RUN} rst_state_t`;
  - `localparam SYNC_STAGES = 2`;
  - `localparam LOSS_CNT_W = 8`.
- Sub-module `sync_2ff`: parameterised reset value, instantiated once for `pll_locked` and once for `ext_reset_n`.
- Everything else is one always_ff block plus the next-state logic in the top module.

## Test plan
- Power-up, `pll_locked` = 1, HOLD_CYCLES = 4, LOCK_CYCLES = 8 → `sys_reset` falls exactly 13 edges after `reset` deasserts, and `ready` = 1 on the same edge.
- `pll_locked` rises 50 cycles after reset, LOCK_CYCLES = 8 → state 1 → 2 two edges after sampling, then RUN 8 edges later.
- In SETTLE, drop `pll_locked` for 1 cycle at count 5 → return to WAIT_LOCK, then a full 8-cycle requalification, with `lock_loss_count` unchanged.
- In RUN, pulse `pll_locked` low 300 times → `sys_reset` reasserts 2 edges after each pulse, and `lock_loss_count` saturates at 255.
- With debounce, DEBOUNCE_CYCLES = 10: 9-cycle low glitch on `ext_reset_n` → no effect; 12-cycle low → HOLD, `sys_reset` = 1 at edge 12.
- Without the macro: 1-cycle low on `ext_reset_n` → HOLD 2 edges later, then the normal release sequence.
